// File: rtl/vc_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo: per-virtual-channel flit FIFO with first-word fall-through read
// port, per-VC occupancy/status flags, read credits and sticky error flags.
// Each VC owns DEPTH private entries plus private read/write pointers.
// ---------------------------------------------------------------------------
module vc_fifo #(
   parameter  int WIDTH      = 32,
   parameter  int DEPTH_LOG2 = 2,
   parameter  int NUM_VC     = 2,
   parameter  int AF_MARGIN  = 1,
   localparam int DEPTH      = 1 << DEPTH_LOG2,
   localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   localparam int CW         = DEPTH_LOG2 + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en_i,
   input  logic [VC_W-1:0]      wr_vc_i,
   input  logic [WIDTH-1:0]     wr_data_i,
   input  logic                 rd_en_i,
   input  logic [VC_W-1:0]      rd_vc_i,
   output logic [WIDTH-1:0]     rd_data_o,
   output logic [NUM_VC-1:0]    full_o,
   output logic [NUM_VC-1:0]    empty_o,
   output logic [NUM_VC-1:0]    almost_full_o,
   output logic [NUM_VC*CW-1:0] count_o,
   output logic [NUM_VC-1:0]    credit_out_o,
   output logic                 ovf_err_o,
   output logic                 unf_err_o,
   input  logic                 err_clr_i
);

   logic [WIDTH-1:0]      mem_q    [NUM_VC][DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q [NUM_VC];
   logic [DEPTH_LOG2-1:0] wr_ptr_d [NUM_VC];
   logic [DEPTH_LOG2-1:0] rd_ptr_q [NUM_VC];
   logic [DEPTH_LOG2-1:0] rd_ptr_d [NUM_VC];
   logic [CW-1:0]         cnt_q    [NUM_VC];
   logic [CW-1:0]         cnt_d    [NUM_VC];
   logic [NUM_VC-1:0]     credit_q;
   logic                  ovf_q;
   logic                  ovf_d;
   logic                  unf_q;
   logic                  unf_d;

   logic                  wr_vc_ok_s;
   logic                  rd_vc_ok_s;
   logic [VC_W-1:0]       wr_idx_s;
   logic [VC_W-1:0]       rd_idx_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic [NUM_VC-1:0]     wr_sel_s;
   logic [NUM_VC-1:0]     rd_sel_s;

   // Status flags decoded straight from the registered per-VC counts.
   always_comb begin
      full_o        = {NUM_VC{1'b0}};
      empty_o       = {NUM_VC{1'b0}};
      almost_full_o = {NUM_VC{1'b0}};
      count_o       = {(NUM_VC*CW){1'b0}};
      for (int v = 0; v < NUM_VC; v++) begin
         full_o[v]           = (cnt_q[v] == CW'(DEPTH));
         empty_o[v]          = (cnt_q[v] == {CW{1'b0}});
         almost_full_o[v]    = (cnt_q[v] >= CW'(DEPTH - AF_MARGIN));
         count_o[v*CW +: CW] = cnt_q[v];
      end
   end

   // Accept/reject decision; out-of-range VCs are clamped to 0 for indexing only.
   always_comb begin
      wr_vc_ok_s = (32'(wr_vc_i) < NUM_VC);
      rd_vc_ok_s = (32'(rd_vc_i) < NUM_VC);
      if (wr_vc_ok_s) begin
         wr_idx_s = wr_vc_i;
      end else begin
         wr_idx_s = {VC_W{1'b0}};
      end
      if (rd_vc_ok_s) begin
         rd_idx_s = rd_vc_i;
      end else begin
         rd_idx_s = {VC_W{1'b0}};
      end
      wr_acc_s = wr_en_i & wr_vc_ok_s & ~full_o[wr_idx_s];
      rd_acc_s = rd_en_i & rd_vc_ok_s & ~empty_o[rd_idx_s];
      wr_sel_s = {NUM_VC{1'b0}};
      rd_sel_s = {NUM_VC{1'b0}};
      for (int v = 0; v < NUM_VC; v++) begin
         wr_sel_s[v] = wr_acc_s & (wr_idx_s == VC_W'(v));
         rd_sel_s[v] = rd_acc_s & (rd_idx_s == VC_W'(v));
      end
   end

   // Fall-through head of the selected VC; zero when empty or out of range (no write bypass).
   always_comb begin
      if (rd_vc_ok_s && !empty_o[rd_idx_s]) begin
         rd_data_o = mem_q[rd_idx_s][rd_ptr_q[rd_idx_s]];
      end else begin
         rd_data_o = {WIDTH{1'b0}};
      end
   end

   // Next-state for pointers, counts and sticky errors (a new error beats a clear).
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         wr_ptr_d[v] = wr_ptr_q[v];
         rd_ptr_d[v] = rd_ptr_q[v];
         cnt_d[v]    = cnt_q[v];
         if (wr_sel_s[v]) begin
            wr_ptr_d[v] = wr_ptr_q[v] + DEPTH_LOG2'(1);
         end else begin
            wr_ptr_d[v] = wr_ptr_q[v];
         end
         if (rd_sel_s[v]) begin
            rd_ptr_d[v] = rd_ptr_q[v] + DEPTH_LOG2'(1);
         end else begin
            rd_ptr_d[v] = rd_ptr_q[v];
         end
         case ({wr_sel_s[v], rd_sel_s[v]})
            2'b10:   cnt_d[v] = cnt_q[v] + CW'(1);
            2'b01:   cnt_d[v] = cnt_q[v] - CW'(1);
            default: cnt_d[v] = cnt_q[v];
         endcase
      end
      ovf_d = (wr_en_i & ~wr_acc_s) | (ovf_q & ~err_clr_i);
      unf_d = (rd_en_i & ~rd_acc_s) | (unf_q & ~err_clr_i);
   end

   // Flit storage: written at the VC's write pointer on an accepted write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VC; v++) begin
            for (int e = 0; e < DEPTH; e++) begin
               mem_q[v][e] <= {WIDTH{1'b0}};
            end
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (wr_sel_s[v]) begin
               mem_q[v][wr_ptr_q[v]] <= wr_data_i;
            end
         end
      end
   end

   // Pointer, count, credit and error registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_q[v] <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q[v] <= {DEPTH_LOG2{1'b0}};
            cnt_q[v]    <= {CW{1'b0}};
         end
         credit_q <= {NUM_VC{1'b0}};
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_q[v] <= wr_ptr_d[v];
            rd_ptr_q[v] <= rd_ptr_d[v];
            cnt_q[v]    <= cnt_d[v];
         end
         credit_q <= rd_sel_s;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign credit_out_o = credit_q;
   assign ovf_err_o    = ovf_q;
   assign unf_err_o    = unf_q;

endmodule

// File: tb/tb_vc_fifo.sv
// ---------------------------------------------------------------------------
// tb_vc_fifo: directed and random stimulus for vc_fifo, checked against a
// queue-based reference model of per-VC FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_vc_fifo;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 4;
   localparam int NUM_VC = 2;
   localparam int CW     = 3;
   localparam int AF_LVL = 3;

   logic                 clk   = 1'b0;
   logic                 reset = 1'b0;
   logic                 wr_en = 1'b0;
   logic                 wr_vc = 1'b0;
   logic [WIDTH-1:0]     wr_data = 32'h0;
   logic                 rd_en = 1'b0;
   logic                 rd_vc = 1'b0;
   logic                 err_clr = 1'b0;
   logic [WIDTH-1:0]     rd_data;
   logic [NUM_VC-1:0]    full, empty, almost_full, credit_out;
   logic [NUM_VC*CW-1:0] count;
   logic                 ovf_err, unf_err;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   logic [WIDTH-1:0] mq [NUM_VC][$];
   logic [NUM_VC-1:0] m_credit = 2'b00;
   logic m_ovf = 1'b0;
   logic m_unf = 1'b0;

   vc_fifo dut (
      .clk(clk), .reset(reset),
      .wr_en_i(wr_en), .wr_vc_i(wr_vc), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_vc_i(rd_vc), .rd_data_o(rd_data),
      .full_o(full), .empty_o(empty), .almost_full_o(almost_full),
      .count_o(count), .credit_out_o(credit_out),
      .ovf_err_o(ovf_err), .unf_err_o(unf_err), .err_clr_i(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [WIDTH-1:0] exp_rd;
      for (int v = 0; v < NUM_VC; v++) begin
         chk($sformatf("%s count%0d", tag, v), 64'(count[v*CW +: CW]), 64'(mq[v].size()));
         chk($sformatf("%s full%0d", tag, v), 64'(full[v]), 64'(mq[v].size() == DEPTH));
         chk($sformatf("%s empty%0d", tag, v), 64'(empty[v]), 64'(mq[v].size() == 0));
         chk($sformatf("%s afull%0d", tag, v), 64'(almost_full[v]), 64'(mq[v].size() >= AF_LVL));
      end
      exp_rd = (mq[rd_vc].size() > 0) ? mq[rd_vc][0] : 32'h0;
      chk({tag, " rd_data"}, 64'(rd_data), 64'(exp_rd));
      chk({tag, " credit"}, 64'(credit_out), 64'(m_credit));
      chk({tag, " ovf"}, 64'(ovf_err), 64'(m_ovf));
      chk({tag, " unf"}, 64'(unf_err), 64'(m_unf));
   endtask

   // one clock cycle with the given inputs, then model update and full check
   task automatic step(input string tag, input logic we, input logic wv, input logic [WIDTH-1:0] wd,
                       input logic re, input logic rv, input logic clr);
      bit wok, rok;
      wr_en = we; wr_vc = wv; wr_data = wd; rd_en = re; rd_vc = rv; err_clr = clr;
      wok = we && (mq[wv].size() < DEPTH);
      rok = re && (mq[rv].size() > 0);
      @(posedge clk);
      #1;
      if (rok) void'(mq[rv].pop_front());
      if (wok) mq[wv].push_back(wd);
      m_credit = rok ? (2'b01 << rv) : 2'b00;
      m_ovf = (we && !wok) || (m_ovf && !clr);
      m_unf = (re && !rok) || (m_unf && !clr);
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check_all("reset");
      chk("reset empty", 64'(empty), 64'(2'b11));
      @(negedge clk);
      reset = 1'b0;
      idle("post_reset");

      // fill VC0 with A0..A3
      for (int i = 0; i < 4; i++) begin
         step($sformatf("fill%0d", i), 1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
         chk($sformatf("fill%0d af0", i), 64'(almost_full[0]), 64'(i >= 2));
      end
      chk("fill full0", 64'(full[0]), 64'd1);
      chk("fill count0", 64'(count[CW-1:0]), 64'd4);
      chk("fill empty1", 64'(empty[1]), 64'd1);
      chk("head A0", 64'(rd_data), 64'hA0);

      // full VC0: read + write -> read accepted, write rejected
      step("full_rw", 1'b1, 1'b0, 32'hEE, 1'b1, 1'b0, 1'b0);
      chk("full_rw ovf", 64'(ovf_err), 64'd1);
      chk("full_rw credit", 64'(credit_out), 64'd1);
      chk("full_rw count0", 64'(count[CW-1:0]), 64'd3);
      chk("full_rw head", 64'(rd_data), 64'hA1);
      step("clr", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step("drain1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // VC0 holds 2; simultaneous write/read across pointer wrap
      for (int i = 0; i < 10; i++) begin
         step($sformatf("wrap%0d", i), 1'b1, 1'b0, 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b0);
         chk($sformatf("wrap%0d count0", i), 64'(count[CW-1:0]), 64'd2);
      end

      // underflow on empty VC1, clear, clear with new underflow
      step("unf", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("unf flag", 64'(unf_err), 64'd1);
      chk("unf credit", 64'(credit_out), 64'd0);
      step("unf_clr", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("unf cleared", 64'(unf_err), 64'd0);
      step("unf_set_wins", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("unf set wins", 64'(unf_err), 64'd1);
      step("clr2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

      // empty VC1: write+read same cycle, no bypass
      step("nobypass", 1'b1, 1'b1, 32'hD1, 1'b1, 1'b1, 1'b0);
      step("drain_v1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

      // write VC1 while reading VC0
      step("cross", 1'b1, 1'b1, 32'hC1, 1'b1, 1'b0, 1'b0);
      chk("cross count1", 64'(count[2*CW-1:CW]), 64'd1);
      chk("cross credit", 64'(credit_out), 64'(2'b01));

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), 1'($urandom),
              $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom),
              1'($urandom_range(0, 15) == 0));
      end

      // build up occupancy then reset between edges
      step("pre_rst0", 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0);
      step("pre_rst1", 1'b1, 1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int v = 0; v < NUM_VC; v++) mq[v].delete();
      m_credit = 2'b00; m_ovf = 1'b0; m_unf = 1'b0;
      check_all("midrst");
      chk("midrst rd_data", 64'(rd_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      step("after_rst_rd", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("after_rst credit", 64'(credit_out), 64'd0);
      step("after_rst_wr", 1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter WIDTH, default 32, flit width in bits.
REQ-002 Parameter DEPTH_LOG2, default 2, log2 of per-VC depth; DEPTH = 1<<DEPTH_LOG2.
REQ-003 Parameter NUM_VC, default 2, number of virtual channels, legal range 1..16.
REQ-004 Parameter AF_MARGIN, default 1, almost-full margin, legal range 1..DEPTH-1.
REQ-005 Derived VC_W = max(1, clog2(NUM_VC)); CW = DEPTH_LOG2+1.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_vc  input  VC_W  target VC of write.
REQ-010 wr_data  input  WIDTH  flit to store.
REQ-011 rd_en  input  1  read (pop) request.
REQ-012 rd_vc  input  VC_W  VC to read/peek.
REQ-013 rd_data  output  WIDTH  head flit of rd_vc, combinational (first-word fall-through).
REQ-014 full  output  NUM_VC  per-VC full flag.
REQ-015 empty  output  NUM_VC  per-VC empty flag.
REQ-016 almost_full  output  NUM_VC  per-VC count >= DEPTH-AF_MARGIN.
REQ-017 count  output  NUM_VC*CW  packed per-VC occupancy, VC v at bits [v*CW +: CW].
REQ-018 credit_out  output  NUM_VC  one-cycle pulse per accepted read, per VC.
REQ-019 ovf_err  output  1  sticky: rejected write.
REQ-020 unf_err  output  1  sticky: rejected read.
REQ-021 err_clr  input  1  synchronous clear of ovf_err/unf_err.

Function
REQ-022 Each VC SHALL own DEPTH entries plus private read/write pointers (DEPTH_LOG2 bits, wrap modulo DEPTH) and a CW-bit count register.
REQ-023 full[v] = (count[v]==DEPTH), empty[v] = (count[v]==0), almost_full[v] per REQ-016; all decoded from registered count, no extra latency.
REQ-024 Accepted write = wr_en & wr_vc<NUM_VC & !full[wr_vc] at cycle start; entry written at write pointer, pointer +1.
REQ-025 Accepted read = rd_en & rd_vc<NUM_VC & !empty[rd_vc] at cycle start; read pointer +1; rd_data then shows next entry next cycle.
REQ-026 Count update per VC: +1 write only, -1 read only, unchanged when both or neither.
REQ-027 Read and write to same VC same cycle: both accepted if non-empty and non-full; on full VC write rejected even with read; on empty VC read rejected, no bypass of wr_data to rd_data.
REQ-028 Read and write to different VCs SHALL proceed independently in the same cycle.
REQ-029 rd_data SHALL be 0 when empty[rd_vc] or rd_vc>=NUM_VC.
REQ-030 credit_out[v] SHALL pulse high the cycle after an accepted read on v, low otherwise.
REQ-031 ovf_err set the cycle after wr_en is rejected (full or out-of-range VC); unf_err likewise for rejected rd_en; rejected operations change no other state.
REQ-032 err_clr clears both error flags next cycle; a same-cycle set wins over clear.

Reset
REQ-033 On reset assertion, immediately: all pointers and counts 0, empty all 1, full/almost_full/credit_out all 0, ovf_err/unf_err 0, storage cleared to 0.
REQ-034 Reset mid-operation SHALL discard all stored flits without credit pulses; first edge after deassertion behaves as from empty.

Verification
REQ-035 Defaults; write 0xA0..0xA3 to VC0 -> count0 4, full[0]=1, almost_full[0] set after 3rd write, empty[1] stays 1.
REQ-036 VC0 full; wr_en+rd_en on VC0 -> read accepted (rd_data 0xA0), write rejected, ovf_err=1, count0=3, credit_out[0] pulse.
REQ-037 VC0 holds 2; simultaneous write 0xB0 and read VC0 -> count0 stays 2, order preserved across pointer wrap over 8+ ops.
REQ-038 Read on empty VC1 -> unf_err=1, count1=0, no credit; err_clr -> 0 next cycle; err_clr with new underflow -> stays 1.
REQ-039 Write VC1 0xC1 while reading VC0 -> both accepted, count1=1, credit_out=2'b01.
REQ-040 Reset asserted mid-burst between edges -> outputs return to reset values immediately, rd_data 0, no credit pulse.
